ddr_area_manager: RTL
=====================

Name: ddr_area_manager

Overview:
- Address and buffer-space controller for the AXIS/AXI4 DDR bridge.
- Upstream of the bridge's read path and beside its write path: answers write-allocation requests with DDR addresses, and keeps per-area packet descriptors.
- Issues read commands (addr/len/strb) back to the bridge for a scheduler-selected area.
- Manages 8 DDR areas (one per tdest), each a ring of 128-byte slots.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, DDR address width.
- C_DDR_BASE_ADDR, 32'h0000_0000, base address of area 0.
- C_AREA_SIZE_LOG2, 20, log2 of area size in bytes; must be ≥17 so any 16-bit len fits.
- C_DESC_DEPTH, 4, descriptor FIFO depth per area; power of 2.

Ports:
- M_AXI_ACLK  in  1  single clock.
- M_AXI_ARESETN  in  1  asynchronous reset, active low.
- i_wr_ddr_req  in  1  write allocation request, one-cycle pulse.
- i_wr_ddr_len  in  16  packet length in bytes.
- i_wr_ddr_area  in  3  target area (tdest).
- i_wr_ddr_cpl  in  1  pulse: granted packet fully written to DDR.
- o_wr_ddr_addr  out  ADDR  granted write start address.
- o_wr_ddr_valid  out  1  one-cycle grant strobe.
- i_rd_area_req  in  1  scheduler pulse: read next packet of i_rd_area.
- i_rd_area  in  3  area to read.
- o_area_nonempty  out  8  bit k = area k holds ≥1 committed packet.
- o_rd_ddr_req  out  1  read command pulse.
- o_rd_ddr_valid  out  1  same cycle as o_rd_ddr_req.
- o_rd_ddr_addr  out  ADDR  packet start address.
- o_rd_ddr_len  out  16  packet length in bytes.
- o_rd_ddr_strb  out  8  keep mask for the last beat.
- i_rd_ddr_ready  in  1  bridge can accept a read command.
- i_rd_ddr_cpl  in  1  pulse: read packet fully delivered.

Behaviour:
- **Reset.** Asynchronous on M_AXI_ARESETN low. All outputs are 0. Every area has free = 2^C_AREA_SIZE_LOG2, woff = 0, and an empty FIFO. Both FSMs return to idle. Any in-flight grant or read is abandoned without a descriptor push or a free credit.
- **Allocation arithmetic.**
  - alloc = ceil(len/128)*128 bytes, computed at 17 bits.
  - If woff + alloc > 2^LOG2: start = 0 and charge = alloc + (2^LOG2 − woff), i.e. the tail is skipped. Otherwise start = woff and charge = alloc.
  - Address = C_DDR_BASE_ADDR + (area << LOG2) + start.
- **Write FSM states: W_IDLE, W_CHECK, W_GRANT, W_WAIT_CPL.**
  - W_IDLE: on i_wr_ddr_req, latch len/area and go to W_CHECK. A request with len = 0 is dropped and the FSM stays in W_IDLE.
  - W_CHECK: go to W_GRANT if free[area] ≥ charge and the area FIFO is not full. Otherwise stay in W_CHECK and re-evaluate every cycle; this stall has no timeout.
  - W_GRANT: o_wr_ddr_valid = 1 for one cycle with o_wr_ddr_addr. In the same cycle: free −= charge, woff = (start + alloc) mod 2^LOG2.
  - W_WAIT_CPL: on i_wr_ddr_cpl, push {start, len, charge} into the area FIFO and go to W_IDLE.
  - Latency: request at cycle N gives grant at N+2 when space is available.
  - i_wr_ddr_req outside W_IDLE is ignored. i_wr_ddr_cpl outside W_WAIT_CPL is ignored.
- **Read FSM states: R_IDLE, R_ISSUE, R_WAIT_CPL.**
  - R_IDLE: on i_rd_area_req to an area with nonempty = 1, latch the area and go to R_ISSUE. A request to an empty area is ignored.
  - R_ISSUE: wait for i_rd_ddr_ready. Then pulse o_rd_ddr_req and o_rd_ddr_valid for one cycle with addr/len from the FIFO head (no pop yet).
  - o_rd_ddr_strb: 8'hFF if len[2:0] = 0, else (1<<len[2:0]) − 1, LSB-first.
  - R_WAIT_CPL: on i_rd_ddr_cpl, pop the head, free += charge, go to R_IDLE.
  - i_rd_area_req outside R_IDLE is ignored.
- **Simultaneous events.**
  - A grant debit and a read-cpl credit on the same area in the same cycle both apply (net update).
  - A push and a pop on the same area in the same cycle both apply; FIFO count is unchanged.
  - o_area_nonempty is registered from FIFO count and updates the cycle after a push or pop.
- **Invariant.** Free never exceeds 2^LOG2. Sum of outstanding charges + free = area size.

Test Plan:
- Reset, then len=100 area=3 → grant addr 0x0030_0000 at N+2. After cpl, o_area_nonempty = 8'h08. Next len=200 area=3 → addr 0x0030_0080.
- Read area 3 with ready = 1 → rd addr 0x0030_0000, len 100, strb 8'h0F. After cpl, free[3] is restored by 128.
- Wrap: fill area 0 to woff = 0xFFF80 via repeated grants, then read all back to free space. Request len=256 → addr 0x0000_0000, charge = 128 + 256.
- Full stall: area 1 with free < alloc → no grant. An i_rd_ddr_cpl of area 1 packet → grant the cycle after free suffices.
- Descriptor FIFO full: four committed packets in area 2, fifth request stalls in W_CHECK. One read cpl → grant follows.
- Edge cases: len=0 → no grant. Read request to empty area 5 → no o_rd_ddr_req. Reset asserted in W_WAIT_CPL → all outputs 0, free = 2^20, a later cpl is ignored.

Source files
------------

// File: rtl/ddr_area_manager.sv
// Allocates DDR space for the AXIS/AXI4 DDR bridge: eight ring areas of 128-byte slots,
// each with a small FIFO of committed packet descriptors that feeds the read command path.
module ddr_area_manager #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_DDR_BASE_ADDR = '0,
    parameter int C_AREA_SIZE_LOG2 = 20,
    parameter int C_DESC_DEPTH = 4
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          i_wr_ddr_req,
    input  logic [15:0]                   i_wr_ddr_len,
    input  logic [2:0]                    i_wr_ddr_area,
    input  logic                          i_wr_ddr_cpl,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_wr_ddr_addr,
    output logic                          o_wr_ddr_valid,
    input  logic                          i_rd_area_req,
    input  logic [2:0]                    i_rd_area,
    output logic [7:0]                    o_area_nonempty,
    output logic                          o_rd_ddr_req,
    output logic                          o_rd_ddr_valid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_rd_ddr_addr,
    output logic [15:0]                   o_rd_ddr_len,
    output logic [7:0]                    o_rd_ddr_strb,
    input  logic                          i_rd_ddr_ready,
    input  logic                          i_rd_ddr_cpl
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int L  = C_AREA_SIZE_LOG2;
    localparam int FW = L + 1;
    localparam int PW = (C_DESC_DEPTH > 1) ? $clog2(C_DESC_DEPTH) : 1;
    localparam logic [FW-1:0] AREA_BYTES = {1'b1, {L{1'b0}}};
    localparam logic [PW:0]   DEPTH      = (PW + 1)'(C_DESC_DEPTH);
    localparam logic [PW:0]   CNT_ONE    = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    // state      | meaning
    // W_IDLE     | waiting for a write allocation request
    // W_CHECK    | waiting for enough free space and a free descriptor slot
    // W_GRANT    | one-cycle grant strobe; debit free space, advance write offset
    // W_WAIT_CPL | granted packet in flight; commit descriptor on completion
    // R_IDLE     | waiting for a scheduler request to a non-empty area
    // R_ISSUE    | waiting for bridge ready to issue the head packet
    // R_WAIT_CPL | read in flight; pop head and credit space on completion
    typedef enum logic [1:0] {W_IDLE, W_CHECK, W_GRANT, W_WAIT_CPL} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT_CPL} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [15:0]   w_len_q;
    logic [2:0]    w_area_q, r_area_q;
    logic [L-1:0]  start_q;
    logic [FW-1:0] charge_q;

    logic [FW-1:0] free_q [8];
    logic [L-1:0]  woff_q [8];
    logic [PW:0]   cnt_q  [8];
    logic [PW-1:0] wptr_q [8];
    logic [PW-1:0] rptr_q [8];
    logic [FW-1:0] free_next [8];
    logic [PW:0]   cnt_next  [8];

    logic [L-1:0]  d_start  [8][C_DESC_DEPTH];
    logic [15:0]   d_len    [8][C_DESC_DEPTH];
    logic [FW-1:0] d_charge [8][C_DESC_DEPTH];

    logic [16:0]   alloc_c;
    logic [FW-1:0] alloc_ext, woff_ext, charge_c;
    logic [L-1:0]  start_c;
    logic          wrap_c, space_ok;
    logic [AW-1:0] wr_addr_c;
    logic          grant, push, pop, rd_fire, wr_req_ok, rd_req_ok;
    logic [L-1:0]  head_start;
    logic [15:0]   head_len;
    logic [FW-1:0] head_charge;
    logic [7:0]    strb_c;

    assign grant     = (w_state == W_GRANT);
    assign push      = (w_state == W_WAIT_CPL) && i_wr_ddr_cpl;
    assign pop       = (r_state == R_WAIT_CPL) && i_rd_ddr_cpl;
    assign rd_fire   = (r_state == R_ISSUE) && i_rd_ddr_ready;
    assign wr_req_ok = i_wr_ddr_req && (i_wr_ddr_len != 16'd0);
    assign rd_req_ok = i_rd_area_req && o_area_nonempty[i_rd_area];

    assign o_wr_ddr_valid = grant;

    assign head_start  = d_start[r_area_q][rptr_q[r_area_q]];
    assign head_len    = d_len[r_area_q][rptr_q[r_area_q]];
    assign head_charge = d_charge[r_area_q][rptr_q[r_area_q]];

    // A packet that would run past the end of the ring restarts at offset 0 and
    // also pays for the skipped tail, so free space always matches real usage.
    always_comb begin
        alloc_c   = ({1'b0, w_len_q} + 17'd127) & 17'h1FF80;
        alloc_ext = FW'(alloc_c);
        woff_ext  = {1'b0, woff_q[w_area_q]};
        wrap_c    = (woff_ext + alloc_ext) > AREA_BYTES;
        start_c   = wrap_c ? '0 : woff_q[w_area_q];
        charge_c  = wrap_c ? (alloc_ext + (AREA_BYTES - woff_ext)) : alloc_ext;
        space_ok  = (free_q[w_area_q] >= charge_c) && (cnt_q[w_area_q] < DEPTH);
        wr_addr_c = C_DDR_BASE_ADDR + (AW'(w_area_q) << L) + AW'(start_c);
        strb_c    = (head_len[2:0] == 3'd0) ? 8'hFF : ((8'd1 << head_len[2:0]) - 8'd1);
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            free_next[k] = free_q[k];
            cnt_next[k]  = cnt_q[k];
            if (grant && (w_area_q == 3'(k))) free_next[k] = free_next[k] - charge_q;
            if (pop && (r_area_q == 3'(k)))   free_next[k] = free_next[k] + head_charge;
            if (push && (w_area_q == 3'(k)))  cnt_next[k]  = cnt_next[k] + CNT_ONE;
            if (pop && (r_area_q == 3'(k)))   cnt_next[k]  = cnt_next[k] - CNT_ONE;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:     if (wr_req_ok)    w_next = W_CHECK;
            W_CHECK:    if (space_ok)     w_next = W_GRANT;
            W_GRANT:                      w_next = W_WAIT_CPL;
            W_WAIT_CPL: if (i_wr_ddr_cpl) w_next = W_IDLE;
            default:                      w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:     if (rd_req_ok)    r_next = R_ISSUE;
            R_ISSUE:    if (rd_fire)      r_next = R_WAIT_CPL;
            R_WAIT_CPL: if (i_rd_ddr_cpl) r_next = R_IDLE;
            default:                      r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            w_len_q         <= '0;
            w_area_q        <= '0;
            r_area_q        <= '0;
            start_q         <= '0;
            charge_q        <= '0;
            o_wr_ddr_addr   <= '0;
            o_area_nonempty <= '0;
            o_rd_ddr_req    <= 1'b0;
            o_rd_ddr_valid  <= 1'b0;
            o_rd_ddr_addr   <= '0;
            o_rd_ddr_len    <= '0;
            o_rd_ddr_strb   <= '0;
            for (int k = 0; k < 8; k++) begin
                free_q[k] <= AREA_BYTES;
                woff_q[k] <= '0;
                cnt_q[k]  <= '0;
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
            end
        end else begin
            if ((w_state == W_IDLE) && wr_req_ok) begin
                w_len_q  <= i_wr_ddr_len;
                w_area_q <= i_wr_ddr_area;
            end
            if ((w_state == W_CHECK) && space_ok) begin
                start_q       <= start_c;
                charge_q      <= charge_c;
                o_wr_ddr_addr <= wr_addr_c;
            end
            if (grant) woff_q[w_area_q] <= L'({1'b0, start_q} + alloc_ext);
            if (push)  wptr_q[w_area_q] <= wptr_q[w_area_q] + PTR_ONE;
            if (pop)   rptr_q[r_area_q] <= rptr_q[r_area_q] + PTR_ONE;
            for (int k = 0; k < 8; k++) begin
                free_q[k]          <= free_next[k];
                cnt_q[k]           <= cnt_next[k];
                o_area_nonempty[k] <= (cnt_next[k] != '0);
            end
            if ((r_state == R_IDLE) && rd_req_ok) r_area_q <= i_rd_area;
            o_rd_ddr_req   <= rd_fire;
            o_rd_ddr_valid <= rd_fire;
            if (rd_fire) begin
                o_rd_ddr_addr <= C_DDR_BASE_ADDR + (AW'(r_area_q) << L) + AW'(head_start);
                o_rd_ddr_len  <= head_len;
                o_rd_ddr_strb <= strb_c;
            end
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (push) begin
            d_start[w_area_q][wptr_q[w_area_q]]  <= start_q;
            d_len[w_area_q][wptr_q[w_area_q]]    <= w_len_q;
            d_charge[w_area_q][wptr_q[w_area_q]] <= charge_q;
        end
    end

endmodule
